// File: rtl/sdm_pkg.sv
// Shared types and defaults for the sigma-delta modulator front end.
package sdm_pkg;

   localparam int unsigned SDM_DATA_W = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2
   } feeder_state_t;

endpackage

// File: rtl/sdm_sync_fifo.sv
// Small synchronous FIFO with a zero-latency head; pushes into a full FIFO are dropped.
module sdm_sync_fifo #(
   parameter int unsigned DATA_W  = 16,
   parameter int unsigned FIFO_AW = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               push,
   input  logic [DATA_W-1:0]  din,
   input  logic               pop,
   output logic [DATA_W-1:0]  dout,
   output logic               full,
   output logic               empty,
   output logic [FIFO_AW:0]   level
);

   localparam int unsigned DEPTH = 1 << FIFO_AW;
   localparam int unsigned CNT_W = FIFO_AW + 1;

   logic [DATA_W-1:0]  mem [DEPTH];
   logic [FIFO_AW-1:0] wr_ptr;
   logic [FIFO_AW-1:0] rd_ptr;
   logic [CNT_W-1:0]   count;
   logic               do_push;
   logic               do_pop;

   // Full is judged on the current count, so a simultaneous pop does not free a slot.
   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];
   assign level   = count;

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + FIFO_AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + FIFO_AW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/sdm_interp_feeder.sv
// PCM sample buffer and linear interpolator feeding the sigma-delta modulator din.
// Optional SDM_FEED_UNDERRUN_CNT_EN adds a saturating underrun_cnt output.
module sdm_interp_feeder
   import sdm_pkg::*;
#(
   parameter int unsigned DATA_W   = SDM_DATA_W,
   parameter int unsigned OSR_LOG2 = 6,
   parameter int unsigned FIFO_AW  = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               enable,
   input  logic               s_valid,
   output logic               s_ready,
   input  logic [DATA_W-1:0]  s_data,
   output logic [DATA_W-1:0]  dout,
   output logic               underrun,
   output logic [FIFO_AW:0]   fifo_level
`ifdef SDM_FEED_UNDERRUN_CNT_EN
   ,
   output logic [15:0]        underrun_cnt
`endif
);

   localparam int unsigned DIFF_W = DATA_W + 1;
   localparam int unsigned ACC_W  = DATA_W + 1 + OSR_LOG2;
   localparam logic [OSR_LOG2-1:0] PHASE_LAST = '1;

   feeder_state_t              state;
   logic [OSR_LOG2-1:0]        phase;
   logic signed [DATA_W-1:0]   prev;
   logic signed [DATA_W-1:0]   cur;
   logic signed [ACC_W-1:0]    acc;
   logic signed [DIFF_W-1:0]   diff;
   logic signed [ACC_W-1:0]    acc_next;
   logic [DATA_W-1:0]          head;
   logic                       full;
   logic                       empty;
   logic                       boundary;
   logic                       pop;
   logic                       starve;

   // prev + floor(acc / OSR), truncated to the modulator width.
   function automatic logic [DATA_W-1:0] interp(input logic signed [DATA_W-1:0] base,
                                                 input logic signed [ACC_W-1:0]  a);
      logic signed [ACC_W-1:0] sum;
      sum = ACC_W'(base) + (a >>> OSR_LOG2);
      return DATA_W'(sum);
   endfunction

   sdm_sync_fifo #(
      .DATA_W  (DATA_W),
      .FIFO_AW (FIFO_AW)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (s_valid),
      .din   (s_data),
      .pop   (pop),
      .dout  (head),
      .full  (full),
      .empty (empty),
      .level (fifo_level)
   );

   assign s_ready  = !full;
   assign boundary = (phase == PHASE_LAST);
   assign pop      = enable && !empty && ((state == IDLE) || boundary);
   assign starve   = enable && (state != IDLE) && boundary && empty;
   assign diff     = DIFF_W'(cur) - DIFF_W'(prev);
   assign acc_next = acc + ACC_W'(diff);

   // Interpolator FSM; dout is registered from the next-cycle prev/acc.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         phase    <= '0;
         prev     <= '0;
         cur      <= '0;
         acc      <= '0;
         dout     <= '0;
         underrun <= 1'b0;
      end else begin
         underrun <= starve;
         if (!enable) begin
            state <= IDLE;
            phase <= '0;
            prev  <= '0;
            cur   <= '0;
            acc   <= '0;
            dout  <= '0;
         end else begin
            case (state)
               IDLE: begin
                  phase <= '0;
                  dout  <= '0;
                  if (!empty) begin
                     state <= RUN;
                     prev  <= '0;
                     cur   <= head;
                     acc   <= '0;
                  end
               end
               RUN, HOLD: begin
                  phase <= phase + OSR_LOG2'(1);
                  if (boundary) begin
                     prev <= cur;
                     acc  <= '0;
                     dout <= cur;
                     if (!empty) begin
                        cur   <= head;
                        state <= RUN;
                     end else begin
                        state <= HOLD;
                     end
                  end else begin
                     acc  <= acc_next;
                     dout <= interp(prev, acc_next);
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

`ifdef SDM_FEED_UNDERRUN_CNT_EN
   // Saturating underrun tally; only rst_n clears it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         underrun_cnt <= '0;
      end else if (starve && (underrun_cnt != 16'hFFFF)) begin
         underrun_cnt <= underrun_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_sdm_interp_feeder.sv
// Directed bench for sdm_interp_feeder (OSR 4 main instance, OSR 64 extremes instance).
module tb_sdm_interp_feeder;

   localparam int unsigned DATA_W  = 16;
   localparam int unsigned FIFO_AW = 2;

   logic clk = 1'b0;
   logic rst_n;
   logic enable, s_valid, s_ready, underrun;
   logic [DATA_W-1:0] s_data, dout;
   logic [FIFO_AW:0]  fifo_level;
   logic enable6, s_valid6, s_ready6, underrun6;
   logic [DATA_W-1:0] s_data6, dout6;
   logic [FIFO_AW:0]  fifo_level6;
`ifdef SDM_FEED_UNDERRUN_CNT_EN
   logic [15:0] ucnt, ucnt6;
`endif

   int n_checks = 0;
   int n_fail   = 0;
   int exp_tab [8];

   always #5 clk = ~clk;

   sdm_interp_feeder #(.DATA_W(DATA_W), .OSR_LOG2(2), .FIFO_AW(FIFO_AW)) u_dut (
      .clk (clk), .rst_n (rst_n), .enable (enable),
      .s_valid (s_valid), .s_ready (s_ready), .s_data (s_data),
      .dout (dout), .underrun (underrun), .fifo_level (fifo_level)
`ifdef SDM_FEED_UNDERRUN_CNT_EN
      , .underrun_cnt (ucnt)
`endif
   );

   sdm_interp_feeder #(.DATA_W(DATA_W), .OSR_LOG2(6), .FIFO_AW(FIFO_AW)) u_dut6 (
      .clk (clk), .rst_n (rst_n), .enable (enable6),
      .s_valid (s_valid6), .s_ready (s_ready6), .s_data (s_data6),
      .dout (dout6), .underrun (underrun6), .fifo_level (fifo_level6)
`ifdef SDM_FEED_UNDERRUN_CNT_EN
      , .underrun_cnt (ucnt6)
`endif
   );

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   function automatic int sdout();
      return int'($signed(dout));
   endfunction

   function automatic int sdout6();
      return int'($signed(dout6));
   endfunction

   task automatic push(input int v);
      s_valid = 1'b1;
      s_data  = DATA_W'(v);
      tick();
      s_valid = 1'b0;
   endtask

   // Load two samples while idle, enable, and follow both interpolation intervals.
   task automatic run_two(input string tag, input int s0, input int s1);
      push(s0);
      push(s1);
      check({tag, "_level"}, int'(fifo_level), 2);
      enable = 1'b1;
      tick();
      for (int i = 0; i < 8; i++) begin
         check($sformatf("%s_dout%0d", tag, i), sdout(), exp_tab[i]);
         tick();
      end
      check({tag, "_hold"}, sdout(), s1);
      check({tag, "_underrun"}, int'(underrun), 1);
   endtask

   task automatic go_idle(input string tag);
      enable = 1'b0;
      tick();
      check({tag, "_idle_dout"}, sdout(), 0);
      check({tag, "_idle_level"}, int'(fifo_level), 0);
   endtask

   initial begin
      int last, v, mono;
      rst_n = 1'b0; enable = 1'b0; s_valid = 1'b0; s_data = '0;
      enable6 = 1'b0; s_valid6 = 1'b0; s_data6 = '0;
      #12;
      check("rst_dout", sdout(), 0);
      check("rst_underrun", int'(underrun), 0);
      check("rst_ready", int'(s_ready), 1);
      check("rst_level", int'(fifo_level), 0);
      rst_n = 1'b1;
      tick();

      // Ramp 0 -> 400 -> 800, then starve into HOLD.
      exp_tab = '{0, 100, 200, 300, 400, 500, 600, 700};
      run_two("up", 400, 800);
`ifdef SDM_FEED_UNDERRUN_CNT_EN
      check("up_cnt1", int'(ucnt), 1);
`endif
      tick();
      check("hold_pulse_end", int'(underrun), 0);
      check("hold_dout", sdout(), 800);
      tick(3);
      check("hold_underrun2", int'(underrun), 1);
      check("hold_dout2", sdout(), 800);
`ifdef SDM_FEED_UNDERRUN_CNT_EN
      check("up_cnt2", int'(ucnt), 2);
`endif
      go_idle("up");

      exp_tab = '{0, 25, 50, 75, 100, 50, 0, -50};
      run_two("fall", 100, -100);
      go_idle("fall");

      exp_tab = '{0, 0, 0, 0, 0, 0, 1, 2};
      run_two("floor_pos", 0, 3);
      go_idle("floor_pos");

      exp_tab = '{0, -1, -2, -3, -3, -3, -3, -3};
      run_two("floor_neg", -3, -3);
      go_idle("floor_neg");

      // Fill while disabled; pushes beyond four are refused, including on the pop cycle.
      s_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         s_data = DATA_W'(10 * (i + 1));
         tick();
         if (i == 3) check("fill_ready_low", int'(s_ready), 0);
      end
      check("fill_level", int'(fifo_level), 4);
      s_data = DATA_W'(99);
      enable = 1'b1;
      tick();
      s_valid = 1'b0;
      check("drain_level", int'(fifo_level), 3);
      check("drain_ready", int'(s_ready), 1);
      check("drain_dout0", sdout(), 0);
      for (int k = 0; k < 4; k++) begin
         tick(4);
         check($sformatf("drain_order%0d", k), sdout(), 10 * (k + 1));
      end
      check("drain_underrun", int'(underrun), 1);
      go_idle("drain");

      // Asynchronous reset in the middle of a ramp.
      push(1000);
      push(2000);
      push(3000);
      enable = 1'b1;
      tick(3);
      check("mid_dout", sdout(), 500);
      check("mid_level", int'(fifo_level), 2);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_dout", sdout(), 0);
      check("arst_level", int'(fifo_level), 0);
      check("arst_ready", int'(s_ready), 1);
      check("arst_underrun", int'(underrun), 0);
`ifdef SDM_FEED_UNDERRUN_CNT_EN
      check("arst_cnt", int'(ucnt), 0);
`endif
      enable = 1'b0;
      #1;
      rst_n = 1'b1;
      tick();
      check("post_rst_dout", sdout(), 0);

      // Full-scale step at OSR 64: -32768 -> 32767 must ramp without wrapping.
      s_valid6 = 1'b1;
      s_data6  = 16'h8000;
      tick();
      s_data6  = 16'h7FFF;
      tick();
      s_valid6 = 1'b0;
      check("ext_level", int'(fifo_level6), 2);
      check("ext_ready", int'(s_ready6), 1);
      enable6 = 1'b1;
      tick();
      check("ext_start", sdout6(), 0);
      tick(64);
      check("ext_p0", sdout6(), -32768);
      last = -32768;
      mono = 1;
      for (int p = 1; p < 64; p++) begin
         tick();
         v = sdout6();
         if (v < last) mono = 0;
         last = v;
         check($sformatf("ext_p%0d", p), v, -32768 + ((65535 * p) >>> 6));
      end
      check("ext_monotonic", mono, 1);
      tick();
      check("ext_end", sdout6(), 32767);
      check("ext_underrun", int'(underrun6), 1);
      enable6 = 1'b0;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
